// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encoding,
// byte-lane constants, the default idle timeout and the checksum step.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_DATA = 3'd2,
        ST_CHK  = 3'd3,
        ST_DONE = 3'd4,
        ST_ERR  = 3'd5
    } ldr_state_t;

    localparam int unsigned TIMEOUT_CYC_DEF = 65535;

    localparam logic [1:0] LANE_FIRST = 2'd0;
    localparam logic [1:0] LANE_LAST  = 2'd3;

    function automatic logic [7:0] csum_next(input logic [7:0] csum, input logic [7:0] b);
        return csum ^ b;
    endfunction

endpackage

// File: rtl/ldr_word_packer.sv
// Assembles little-endian data bytes into 32-bit words and keeps the running
// XOR checksum of every data byte since the last clear.
module ldr_word_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_valid,
    output logic [7:0]  csum
);

    logic [1:0]  byte_idx_r;
    logic [23:0] lane_r;
    logic [7:0]  csum_r;

    // Lanes 0..2 are stored; lane 3 is merged straight from the input byte.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_idx_r <= LANE_FIRST;
            lane_r     <= 24'h000000;
            csum_r     <= 8'h00;
        end else if (clr) begin
            byte_idx_r <= LANE_FIRST;
            lane_r     <= 24'h000000;
            csum_r     <= 8'h00;
        end else if (byte_en) begin
            byte_idx_r <= byte_idx_r + 2'd1;
            csum_r     <= csum_next(csum_r, byte_in);
            case (byte_idx_r)
                2'd0:    lane_r[7:0]   <= byte_in;
                2'd1:    lane_r[15:8]  <= byte_in;
                2'd2:    lane_r[23:16] <= byte_in;
                default: lane_r        <= lane_r;
            endcase
        end
    end

    // Word is complete when the lane-3 byte is being accepted.
    always_comb begin
        word       = {byte_in, lane_r};
        word_valid = byte_en && (byte_idx_r == LANE_LAST);
        csum       = csum_r;
    end

endmodule

// File: rtl/imem_loader.sv
// Fills imem from a host byte stream (count header, little-endian words, XOR
// checksum) and keeps the core held in reset until a load completes cleanly.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W      = 6,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter bit HOLD_AT_RST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wd,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int IW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [IW-1:0]     IDLE_LIMIT = IW'(TIMEOUT_CYC - 1);
    localparam logic [IW-1:0]     IDLE_ONE   = {{(IW-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   WORDS_ONE  = {{ADDR_W{1'b0}}, 1'b1};

    ldr_state_t        state_r;
    logic [ADDR_W-1:0] last_idx_r;
    logic [ADDR_W-1:0] word_cnt_r;
    logic [IW-1:0]     idle_r;

    logic              active_s;
    logic              accept_s;
    logic              launch_s;
    logic              data_byte_s;
    logic              timeout_s;
    logic [31:0]       word_s;
    logic              word_valid_s;
    logic [7:0]        csum_s;

    // rx_ready is a registered copy of "state is HDR/DATA/CHK".
    always_comb begin
        active_s    = (state_r == ST_HDR) || (state_r == ST_DATA) || (state_r == ST_CHK);
        accept_s    = rx_valid && rx_ready;
        launch_s    = start && !active_s;
        data_byte_s = accept_s && (state_r == ST_DATA);
        timeout_s   = (idle_r == IDLE_LIMIT);
    end

    ldr_word_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clr        (launch_s),
        .byte_en    (data_byte_s),
        .byte_in    (rx_data),
        .word       (word_s),
        .word_valid (word_valid_s),
        .csum       (csum_s)
    );

    // Load sequencer; a timeout in any receiving state aborts to ERR.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            rx_ready     <= 1'b0;
            im_we        <= 1'b0;
            im_addr      <= {ADDR_W{1'b0}};
            im_wd        <= 32'h0000_0000;
            cpu_hold     <= HOLD_AT_RST;
            load_done    <= 1'b0;
            load_err     <= 1'b0;
            words_loaded <= {(ADDR_W+1){1'b0}};
            last_idx_r   <= {ADDR_W{1'b0}};
            word_cnt_r   <= {ADDR_W{1'b0}};
            idle_r       <= {IW{1'b0}};
        end else begin
            im_we <= 1'b0;
            case (state_r)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start) begin
                        state_r      <= ST_HDR;
                        rx_ready     <= 1'b1;
                        cpu_hold     <= 1'b1;
                        load_done    <= 1'b0;
                        load_err     <= 1'b0;
                        words_loaded <= {(ADDR_W+1){1'b0}};
                        word_cnt_r   <= {ADDR_W{1'b0}};
                        idle_r       <= {IW{1'b0}};
                    end
                end
                ST_HDR, ST_DATA, ST_CHK: begin
                    if (accept_s) begin
                        idle_r <= {IW{1'b0}};
                        if (state_r == ST_HDR) begin
                            last_idx_r <= rx_data[ADDR_W-1:0];
                            state_r    <= ST_DATA;
                        end else if (state_r == ST_DATA) begin
                            if (word_valid_s) begin
                                im_we        <= 1'b1;
                                im_addr      <= word_cnt_r;
                                im_wd        <= word_s;
                                word_cnt_r   <= word_cnt_r + ADDR_ONE;
                                words_loaded <= words_loaded + WORDS_ONE;
                                if (word_cnt_r == last_idx_r) begin
                                    state_r <= ST_CHK;
                                end
                            end
                        end else begin
                            rx_ready <= 1'b0;
                            if (rx_data == csum_s) begin
                                state_r   <= ST_DONE;
                                load_done <= 1'b1;
                                cpu_hold  <= 1'b0;
                            end else begin
                                state_r  <= ST_ERR;
                                load_err <= 1'b1;
                            end
                        end
                    end else if (timeout_s) begin
                        state_r  <= ST_ERR;
                        rx_ready <= 1'b0;
                        load_err <= 1'b1;
                    end else begin
                        idle_r <= idle_r + IDLE_ONE;
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    rx_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
